clock_mode_controller: RTL and testbench

- Sequencing controller for the HH:MM:SS clock datapath. Replaces the raw slide-switch/push-button muxing in front of the second/minute/hour counters.
- Mode FSM: RUN / HOLD / SET_MIN / SET_HR.
- Debounces the mode and increment buttons.
- Generates the 1 Hz second tick, single-cycle minute/hour increment strobes, a seconds-clear strobe, and blink-blank controls for the 7-segment digit pairs.

---
 rtl/clock_mode_controller.sv | 243 ++++++++++++++++++++++++
 tb/tb_clock_mode_controller.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_mode_controller.sv
// -----------------------------------------------------------------------------
// clock_mode_controller
//
// Sequencing controller that sits in front of the HH:MM:SS second/minute/hour
// counters. It conditions the hold switch and the two push buttons, runs the
// RUN / HOLD / SET_MIN / SET_HR mode FSM, generates the 1 Hz second tick,
// the single-cycle minute/hour increment and seconds-clear strobes, and the
// blink-blank controls for the minute and hour digit pairs.
//
// Ports
//   i_clk         system clock, all state on the rising edge
//   i_rst_n       asynchronous active-low reset
//   i_hold_sw     hold slide switch (asynchronous level, synchronized only)
//   i_mode_btn    mode push button (asynchronous, active-high, bouncy)
//   i_inc_btn     increment push button (asynchronous, active-high, bouncy)
//   o_sec_tick    one-cycle pulse once per second, RUN only
//   o_min_inc     one-cycle minute increment strobe (SET_MIN)
//   o_hr_inc      one-cycle hour increment strobe (SET_HR)
//   o_sec_clr     one-cycle seconds clear strobe (leaving SET_HR by mode press)
//   o_mode        current state: 00 RUN, 01 HOLD, 10 SET_MIN, 11 SET_HR
//   o_blank_min   blank minute digits (blink phase while in SET_MIN)
//   o_blank_hr    blank hour digits (blink phase while in SET_HR)
// -----------------------------------------------------------------------------
module clock_mode_controller #(
    parameter int CLK_HZ          = 50000000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TIMEOUT_SEC     = 30
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_hold_sw,
    input  logic       i_mode_btn,
    input  logic       i_inc_btn,
    output logic       o_sec_tick,
    output logic       o_min_inc,
    output logic       o_hr_inc,
    output logic       o_sec_clr,
    output logic [1:0] o_mode,
    output logic       o_blank_min,
    output logic       o_blank_hr
);

    localparam int PW = $clog2(CLK_HZ + 1);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_SEC + 1);

    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2);
    localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_SEC);

    // Button index 0 = mode, 1 = inc.
    localparam int BTN_MODE = 0;
    localparam int BTN_INC  = 1;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_HOLD    = 2'b01,
        ST_SET_MIN = 2'b10,
        ST_SET_HR  = 2'b11
    } state_t;

    // Input conditioning and debounce state
    logic            r_hold_meta;
    logic            r_hold_sync;
    logic [1:0]      r_btn_meta;
    logic [1:0]      r_btn_sync;
    logic [1:0]      r_btn_last;
    logic [CW-1:0]   r_db_cnt [2];
    logic [1:0]      r_db;
    logic [1:0]      r_db_d;
    logic [1:0]      r_arm;

    logic [CW-1:0]   w_cnt_nxt [2];
    logic [1:0]      w_stable;
    logic [1:0]      w_press;

    // FSM, prescaler, timeout
    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_presc;
    logic [TW-1:0]   r_to;

    logic            w_wrap;
    logic            w_in_set;
    logic            w_timeout;
    logic            w_phase;

    logic            w_tick_nxt;
    logic            w_min_inc_nxt;
    logic            w_hr_inc_nxt;
    logic            w_sec_clr_nxt;

    logic            r_sec_tick;
    logic            r_min_inc;
    logic            r_hr_inc;
    logic            r_sec_clr;

    // -------------------------------------------------------------------------
    // Debounce: run length of identical synchronized samples, saturating at
    // DB_MAX. The level is accepted once the run reaches DB_MAX samples.
    // -------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_cnt_nxt[i] = r_db_cnt[i];
            if (r_btn_sync[i] != r_btn_last[i]) begin
                w_cnt_nxt[i] = CW'(1);
            end else if (r_db_cnt[i] != DB_MAX) begin
                w_cnt_nxt[i] = r_db_cnt[i] + CW'(1);
            end
        end
        w_stable[0] = (w_cnt_nxt[0] == DB_MAX);
        w_stable[1] = (w_cnt_nxt[1] == DB_MAX);
    end

    // The arm flag only sets after a confirmed-low level, so a button held
    // through reset cannot produce a press until it is released first.
    assign w_press = r_db & ~r_db_d & r_arm;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold_meta <= 1'b0;
            r_hold_sync <= 1'b0;
            r_btn_meta  <= 2'b00;
            r_btn_sync  <= 2'b00;
            r_btn_last  <= 2'b00;
            r_db        <= 2'b00;
            r_db_d      <= 2'b00;
            r_arm       <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_hold_meta <= i_hold_sw;
            r_hold_sync <= r_hold_meta;
            r_btn_meta  <= {i_inc_btn, i_mode_btn};
            r_btn_sync  <= r_btn_meta;
            r_btn_last  <= r_btn_sync;
            r_db_d      <= r_db;
            for (int i = 0; i < 2; i++) begin
                r_db_cnt[i] <= w_cnt_nxt[i];
                if (w_stable[i]) begin
                    r_db[i] <= r_btn_sync[i];
                end
                if (w_stable[i] && !r_btn_sync[i]) begin
                    r_arm[i] <= 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Mode FSM
    // -------------------------------------------------------------------------
    assign w_wrap    = (r_presc == PRESC_MAX);
    assign w_in_set  = r_state[1];
    assign w_timeout = w_in_set && (r_to >= TO_MAX);
    assign w_phase   = (r_presc >= PRESC_HALF);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_hold_sync) begin
            w_state_nxt = ST_HOLD;
        end else if (r_state == ST_HOLD) begin
            w_state_nxt = ST_RUN;
        end else if (w_press[BTN_MODE]) begin
            case (r_state)
                ST_RUN:     w_state_nxt = ST_SET_MIN;
                ST_SET_MIN: w_state_nxt = ST_SET_HR;
                default:    w_state_nxt = ST_RUN;
            endcase
        end else if (w_timeout && !w_press[BTN_INC]) begin
            // An inc press on the timeout cycle counts as activity and wins.
            w_state_nxt = ST_RUN;
        end
    end

    always_comb begin
        w_tick_nxt    = (r_state == ST_RUN) && w_wrap;
        w_min_inc_nxt = !r_hold_sync && (r_state == ST_SET_MIN) &&
                        !w_press[BTN_MODE] && w_press[BTN_INC];
        w_hr_inc_nxt  = !r_hold_sync && (r_state == ST_SET_HR) &&
                        !w_press[BTN_MODE] && w_press[BTN_INC];
        w_sec_clr_nxt = !r_hold_sync && (r_state == ST_SET_HR) &&
                        w_press[BTN_MODE];
        o_blank_min   = (r_state == ST_SET_MIN) && w_phase;
        o_blank_hr    = (r_state == ST_SET_HR) && w_phase;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sec_tick <= 1'b0;
            r_min_inc  <= 1'b0;
            r_hr_inc   <= 1'b0;
            r_sec_clr  <= 1'b0;
        end else begin
            r_sec_tick <= w_tick_nxt;
            r_min_inc  <= w_min_inc_nxt;
            r_hr_inc   <= w_hr_inc_nxt;
            r_sec_clr  <= w_sec_clr_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Prescaler restarts on entry to RUN so the first tick is a full second
    // later. Timeout counts prescaler wraps of inactivity in the set states.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_presc <= '0;
            r_to    <= '0;
        end else begin
            if ((w_state_nxt == ST_RUN) && (r_state != ST_RUN)) begin
                r_presc <= '0;
            end else if (w_wrap) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + PW'(1);
            end

            if (!w_in_set || (w_state_nxt != r_state) || (w_press != 2'b00)) begin
                r_to <= '0;
            end else if (w_wrap) begin
                r_to <= r_to + TW'(1);
            end
        end
    end

    assign o_sec_tick = r_sec_tick;
    assign o_min_inc  = r_min_inc;
    assign o_hr_inc   = r_hr_inc;
    assign o_sec_clr  = r_sec_clr;
    assign o_mode     = r_state;

endmodule

// File: tb/tb_clock_mode_controller.sv
module tb_clock_mode_controller;

    localparam int CLK_HZ = 20;
    localparam int DB     = 4;
    localparam int TO     = 3;
    localparam int MAXC   = 8192;

    // Event kinds: 1 tick, 2 min_inc, 3 hr_inc, 4 sec_clr, 8+m mode becomes m
    typedef struct {
        int cyc;
        int kind;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hold_sw = 1'b0;
    logic       mode_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic       sec_tick;
    logic       min_inc;
    logic       hr_inc;
    logic       sec_clr;
    logic [1:0] mode;
    logic       blank_min;
    logic       blank_hr;

    int checks = 0;
    int failures = 0;

    ev_t q[$];

    // Reference model state
    int n = 0;
    bit raw [3][MAXC];
    bit dbv [2][MAXC];
    bit armv[2][MAXC];
    int m_st = 0;
    int m_to = 0;
    int m_base = 0;
    bit exp_bmin = 1'b0;
    bit exp_bhr = 1'b0;
    int prev_mode = 0;

    always #5 clk = ~clk;

    clock_mode_controller #(
        .CLK_HZ(CLK_HZ),
        .DEBOUNCE_CYCLES(DB),
        .TIMEOUT_SEC(TO)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_hold_sw(hold_sw),
        .i_mode_btn(mode_btn),
        .i_inc_btn(inc_btn),
        .o_sec_tick(sec_tick),
        .o_min_inc(min_inc),
        .o_hr_inc(hr_inc),
        .o_sec_clr(sec_clr),
        .o_mode(mode),
        .o_blank_min(blank_min),
        .o_blank_hr(blank_hr)
    );

    // Level seen after the two-stage synchronizer at edge k.
    function automatic bit sync_of(int b, int k);
        if (k < 3) return 1'b0;
        return raw[b][k-2];
    endfunction

    // True when the last DB synchronized samples (ending at edge k) agree.
    function automatic bit stable_at(int b, int k);
        if (k < DB) return 1'b0;
        for (int j = k - DB + 1; j <= k; j++) begin
            if (sync_of(b, j) != sync_of(b, k)) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit press_at(int b, int k);
        if (k < 2) return 1'b0;
        return dbv[b][k-1] && !dbv[b][k-2] && armv[b][k-1];
    endfunction

    // Behavioural reference: predicts output events for each edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            n = 0;
            m_st = 0;
            m_to = 0;
            m_base = 0;
            exp_bmin = 1'b0;
            exp_bhr = 1'b0;
            for (int b = 0; b < 2; b++) begin
                dbv[b][0] = 1'b0;
                armv[b][0] = 1'b0;
            end
        end else begin
            bit hs, pm, pi, wrap, tick, mi, hi, clr, st, ph;
            int nst;
            n = n + 1;
            if (n >= MAXC) begin
                $display("FAIL model_capacity cyc=%0d limit=%0d", n, MAXC);
                $fatal(1, "model history exhausted");
            end
            raw[0][n] = mode_btn;
            raw[1][n] = inc_btn;
            raw[2][n] = hold_sw;
            for (int b = 0; b < 2; b++) begin
                st = stable_at(b, n);
                dbv[b][n]  = st ? sync_of(b, n) : dbv[b][n-1];
                armv[b][n] = armv[b][n-1] | (st && !sync_of(b, n));
            end
            hs = sync_of(2, n);
            pm = press_at(0, n);
            pi = press_at(1, n);
            wrap = (((n - 1 - m_base) % CLK_HZ) == CLK_HZ - 1);
            tick = (m_st == 0) && wrap;
            mi = 1'b0;
            hi = 1'b0;
            clr = 1'b0;
            nst = m_st;
            if (hs) nst = 1;
            else if (m_st == 1) nst = 0;
            else if (pm) begin
                if (m_st == 0) nst = 2;
                else if (m_st == 2) nst = 3;
                else begin
                    nst = 0;
                    clr = 1'b1;
                end
            end else if (pi) begin
                mi = (m_st == 2);
                hi = (m_st == 3);
            end else if (m_st >= 2 && m_to >= TO) nst = 0;

            if (m_st < 2 || nst != m_st || pm || pi) m_to = 0;
            else if (wrap) m_to = m_to + 1;
            if (nst == 0 && m_st != 0) m_base = n;

            if (nst != m_st) q.push_back('{n, 8 + nst});
            if (tick) q.push_back('{n, 1});
            if (mi) q.push_back('{n, 2});
            if (hi) q.push_back('{n, 3});
            if (clr) q.push_back('{n, 4});
            m_st = nst;
            ph = (((n - m_base) % CLK_HZ) >= CLK_HZ / 2);
            exp_bmin = (m_st == 2) && ph;
            exp_bhr = (m_st == 3) && ph;
        end
    end

    task automatic expect_ev(input int kind);
        ev_t e;
        checks++;
        if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event cyc=%0d got_kind=%0d exp=none", n, kind);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.cyc != n) begin
                failures++;
                $display("FAIL event cyc=%0d got_kind=%0d exp_kind=%0d exp_cyc=%0d",
                         n, kind, e.kind, e.cyc);
            end
        end
    endtask

    // Monitor: compares DUT outputs against the scoreboard away from the edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            checks++;
            if ({sec_tick, min_inc, hr_inc, sec_clr, mode, blank_min, blank_hr} != 8'd0) begin
                failures++;
                $display("FAIL reset_outputs got=%b exp=00000000",
                         {sec_tick, min_inc, hr_inc, sec_clr, mode, blank_min, blank_hr});
            end
            q.delete();
            prev_mode = 0;
        end else begin
            if (int'(mode) != prev_mode) begin
                expect_ev(8 + int'(mode));
                prev_mode = int'(mode);
            end
            if (sec_tick) expect_ev(1);
            if (min_inc) expect_ev(2);
            if (hr_inc) expect_ev(3);
            if (sec_clr) expect_ev(4);
            checks++;
            if (blank_min != exp_bmin || blank_hr != exp_bhr) begin
                failures++;
                $display("FAIL blank cyc=%0d got=%b%b exp=%b%b", n,
                         blank_min, blank_hr, exp_bmin, exp_bhr);
            end
            while (q.size() > 0 && q[0].cyc <= n) begin
                checks++;
                failures++;
                $display("FAIL missing_event cyc=%0d got=none exp_kind=%0d exp_cyc=%0d",
                         n, q[0].kind, q[0].cyc);
                void'(q.pop_front());
            end
        end
    end

    task automatic cyc(input int k);
        repeat (k) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_btn(input int b, input logic v);
        if (b == 0) mode_btn = v;
        else inc_btn = v;
    endtask

    task automatic pulse(input int b, input int len);
        set_btn(b, 1'b1);
        cyc(len);
        set_btn(b, 1'b0);
        cyc(10);
    endtask

    initial begin
        rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(45);

        // Full set cycle: SET_MIN, inc, SET_HR, inc, back to RUN with clear
        pulse(0, 10);
        pulse(1, 8);
        pulse(0, 8);
        pulse(1, 8);
        pulse(0, 8);
        cyc(25);

        // Bouncy inc in SET_MIN, then a short glitch
        pulse(0, 8);
        for (int i = 0; i < 12; i++) begin
            inc_btn = ((i / 2) % 2 == 0);
            cyc(1);
        end
        inc_btn = 1'b1;
        cyc(10);
        inc_btn = 1'b0;
        cyc(10);
        inc_btn = 1'b1;
        cyc(3);
        inc_btn = 1'b0;
        cyc(10);

        // Hold while in SET_HR, presses ignored
        pulse(0, 8);
        hold_sw = 1'b1;
        cyc(5);
        pulse(1, 8);
        pulse(0, 8);
        hold_sw = 1'b0;
        cyc(10);

        // Timeout from SET_MIN
        pulse(0, 8);
        cyc(80);

        // Mode held through reset release
        mode_btn = 1'b1;
        cyc(2);
        rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(20);
        mode_btn = 1'b0;
        cyc(10);
        pulse(0, 8);

        // Simultaneous mode and inc in SET_MIN
        mode_btn = 1'b1;
        inc_btn = 1'b1;
        cyc(8);
        mode_btn = 1'b0;
        inc_btn = 1'b0;
        cyc(10);
        pulse(0, 8);

        // Randomized segments
        repeat (400) begin
            hold_sw  = ($urandom_range(0, 99) < 8);
            mode_btn = ($urandom_range(0, 3) == 0);
            inc_btn  = $urandom_range(0, 1) == 1;
            cyc($urandom_range(1, 12));
        end
        hold_sw = 1'b0;
        mode_btn = 1'b0;
        inc_btn = 1'b0;
        cyc(30);

        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL pending_events got=%0d exp=0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
